// File: rtl/pr_elastic_stage_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state encoding,
// default widths and control-field offsets used by the per-stage packers.
package pr_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 128;
  localparam int unsigned CTRL_WIDTH_DEF = 16;
  localparam int unsigned CNT_WIDTH_DEF  = 32;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = S_EMPTY,
    ST_FULL  = S_FULL,
    ST_SKID  = S_SKID
  } pr_state_e;

  // Control payload layout; packers place fields at these offsets.
  localparam int unsigned CTRL_REG_WE_BIT  = 0;
  localparam int unsigned CTRL_FREG_WE_BIT = 1;
  localparam int unsigned CTRL_MEM_RD_LSB  = 2;
  localparam int unsigned CTRL_MEM_RD_W    = 3;
  localparam int unsigned CTRL_MEM_WR_LSB  = 5;
  localparam int unsigned CTRL_MEM_WR_W    = 2;
  localparam int unsigned CTRL_WB_SEL_LSB  = 7;
  localparam int unsigned CTRL_WB_SEL_W    = 2;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic [1:0] occupancy;
  } pr_flags_t;

  // Handshake flags presented while resident in a given state.
  function automatic pr_flags_t state_flags(input pr_state_e s);
    pr_flags_t f;
    f = '{in_ready: 1'b1, out_valid: 1'b0, occupancy: 2'd0};
    case (s)
      ST_FULL: f = '{in_ready: 1'b1, out_valid: 1'b1, occupancy: 2'd1};
      ST_SKID: f = '{in_ready: 1'b0, out_valid: 1'b1, occupancy: 2'd2};
      default: f = '{in_ready: 1'b1, out_valid: 1'b0, occupancy: 2'd0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pr_elastic_stage_stall_counter.sv
// Wrap-around event counter with synchronous clear, used for stall profiling.
module pr_stall_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 EN,
  output logic [CNT_WIDTH-1:0] COUNT
);

  always_ff @(posedge CLK) begin
    if (CLR)
      COUNT <= '0;
    else if (EN)
      COUNT <= COUNT + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/pr_elastic_stage.sv
// Handshaked pipeline register with a 2-entry skid buffer, flush-to-bubble and
// a stall-cycle counter. IN_READY is a pure function of registered state.
module pr_elastic_stage
  import pr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  input  logic                  OUT_READY,
  output logic [1:0]            OCCUPANCY,
  output logic [CNT_WIDTH-1:0]  STALL_CNT
);

  pr_state_e             state_q;
  pr_flags_t             flags_q;
  logic [DATA_WIDTH-1:0] main_data_q;
  logic [CTRL_WIDTH-1:0] main_ctrl_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q;
  logic                  in_fire;
  logic                  out_fire;
  logic                  stall_en;

  assign in_fire  = IN_VALID & flags_q.in_ready;
  assign out_fire = flags_q.out_valid & OUT_READY;
  assign stall_en = flags_q.out_valid & ~OUT_READY;

  assign IN_READY  = flags_q.in_ready;
  assign OUT_VALID = flags_q.out_valid;
  assign OCCUPANCY = flags_q.occupancy;
  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = main_ctrl_q;

  // State, flags and payload registers; flags always track the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_EMPTY;
      flags_q     <= state_flags(ST_EMPTY);
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (FLUSH) begin
      state_q     <= ST_EMPTY;
      flags_q     <= state_flags(ST_EMPTY);
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_q <= IN_DATA;
            main_ctrl_q <= IN_CTRL;
            state_q     <= ST_FULL;
            flags_q     <= state_flags(ST_FULL);
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_data_q <= IN_DATA;
            main_ctrl_q <= IN_CTRL;
          end else if (in_fire) begin
            skid_data_q <= IN_DATA;
            skid_ctrl_q <= IN_CTRL;
            state_q     <= ST_SKID;
            flags_q     <= state_flags(ST_SKID);
          end else if (out_fire) begin
            main_ctrl_q <= '0;
            state_q     <= ST_EMPTY;
            flags_q     <= state_flags(ST_EMPTY);
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            state_q     <= ST_FULL;
            flags_q     <= state_flags(ST_FULL);
          end
        end
        default: begin
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
          state_q     <= ST_EMPTY;
          flags_q     <= state_flags(ST_EMPTY);
        end
      endcase
    end
  end

  pr_stall_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_counter (
    .CLK  (CLK),
    .CLR  (RESET),
    .EN   (stall_en),
    .COUNT(STALL_CNT)
  );

endmodule

// File: tb/tb_pr_elastic_stage.sv
// Self-checking bench: directed scenarios plus random traffic, compared against
// a queue-based FIFO model of the stage.
module tb_pr_elastic_stage;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = 4;

  logic          CLK = 1'b0;
  logic          RESET, FLUSH, IN_VALID, OUT_READY;
  logic [DW-1:0] IN_DATA;
  logic [CW-1:0] IN_CTRL;
  logic          IN_READY, OUT_VALID;
  logic [DW-1:0] OUT_DATA;
  logic [CW-1:0] OUT_CTRL;
  logic [1:0]    OCCUPANCY;
  logic [NW-1:0] STALL_CNT;

  pr_elastic_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL), .OUT_READY(OUT_READY),
    .OCCUPANCY(OCCUPANCY), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [NW-1:0] m_cnt;
  bit            model_ok = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs with the model's view of the held entries.
  task automatic check_outputs();
    int unsigned sz;
    sz = q.size();
    check("out_valid", DW'(OUT_VALID), DW'(sz > 0));
    check("in_ready",  DW'(IN_READY),  DW'(sz < 2));
    check("occupancy", DW'(OCCUPANCY), DW'(sz));
    check("stall_cnt", DW'(STALL_CNT), DW'(m_cnt));
    check("out_ctrl",  DW'(OUT_CTRL),  (sz > 0) ? DW'(q[0].c) : '0);
    if (sz > 0) check("out_data", OUT_DATA, q[0].d);
  endtask

  // Spec-level cycle semantics: stall sampled first, then reset/flush/pop/push.
  task automatic model_update();
    bit ov, ir;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    if (RESET) begin
      q.delete();
      m_cnt = '0;
      model_ok = 1;
    end else begin
      if (ov && !OUT_READY) m_cnt = NW'(m_cnt + 1);
      if (FLUSH) q.delete();
      else begin
        if (ov && OUT_READY) void'(q.pop_front());
        if (IN_VALID && ir) q.push_back('{d: IN_DATA, c: IN_CTRL});
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
    @(negedge CLK);
    if (model_ok) check_outputs();
    RESET = rst; FLUSH = fl; IN_VALID = iv; IN_DATA = d; IN_CTRL = c; OUT_READY = ordy;
    @(posedge CLK);
    model_update();
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; IN_CTRL = '0; OUT_READY = 1'b0;
    m_cnt = '0;

    // Reset with upstream valid asserted
    cycle(1, 0, 1, DW'(77), 16'h00FF, 0);
    cycle(1, 0, 1, DW'(77), 16'h00FF, 0);
    cycle(0, 0, 0, '0, '0, 1);
    #1;
    check("rst_out_valid", DW'(OUT_VALID), '0);
    check("rst_out_ctrl",  DW'(OUT_CTRL),  '0);
    check("rst_occupancy", DW'(OCCUPANCY), '0);
    check("rst_in_ready",  DW'(IN_READY),  DW'(1));
    check("rst_stall_cnt", DW'(STALL_CNT), '0);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, DW'(i), 16'h00A5, 1);
      #1;
      check("stream_in_ready", DW'(IN_READY), DW'(1));
      check("stream_data", OUT_DATA, DW'(i));
    end
    cycle(0, 0, 0, '0, '0, 1);

    // Skid fill, ignored upstream changes, then drain
    cycle(0, 0, 1, DW'(10), 16'h0011, 0);
    cycle(0, 0, 1, DW'(11), 16'h0022, 0);
    cycle(0, 0, 1, DW'(99), 16'h0033, 0);
    cycle(0, 0, 1, DW'(98), 16'h0044, 0);
    #1;
    check("skid_occupancy", DW'(OCCUPANCY), DW'(2));
    check("skid_in_ready",  DW'(IN_READY),  '0);
    check("skid_stall_cnt", DW'(STALL_CNT), DW'(3));
    cycle(0, 0, 0, '0, '0, 1);
    #1;
    check("skid_first",  OUT_DATA, DW'(11));
    cycle(0, 0, 0, '0, '0, 1);
    #1;
    check("skid_drained", DW'(OCCUPANCY), '0);

    // Flush with two held entries and a simultaneous input
    cycle(0, 0, 1, DW'(20), 16'h0055, 0);
    cycle(0, 0, 1, DW'(21), 16'h0066, 0);
    cycle(0, 1, 1, DW'(12), 16'h0077, 0);
    #1;
    check("flush_out_valid", DW'(OUT_VALID), '0);
    check("flush_out_ctrl",  DW'(OUT_CTRL),  '0);
    check("flush_occupancy", DW'(OCCUPANCY), '0);
    cycle(0, 0, 0, '0, '0, 1);
    cycle(0, 0, 0, '0, '0, 1);

    // Counter wrap: 17 stalled cycles on a 4-bit counter
    cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, DW'(30), 16'h0088, 0);
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, '0, '0, 0);
    #1;
    check("wrap_stall_cnt", DW'(STALL_CNT), DW'(1));

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 70),
            {$urandom, $urandom, $urandom, $urandom},
            16'($urandom) | 16'h0001,
            ($urandom_range(0, 99) < 60));
    end
    @(negedge CLK);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
